// File: rtl/apb_if_pkg.sv
// Shared types for the APB requester: FSM state encoding and the registered response bundle.
package apb_if_pkg;

  localparam int unsigned PprotW   = 3;
  localparam int unsigned RspDataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_req_state_e;

  typedef struct packed {
    logic [RspDataW-1:0] rdata;
    logic                err;
    logic                timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_requester.sv
// Single-outstanding APB4 requester: one command in, SETUP/ACCESS on the bus, one response out,
// with an optional ACCESS-phase timeout.
module apb_requester
  import apb_if_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  input  logic [PprotW-1:0]   req_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [PprotW-1:0]   pprot,
  output logic                psel,
  output logic                penable,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_req_state_e state_q, state_d;
  apb_rsp_t       rsp_q, rsp_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0]   paddr_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W/8-1:0] pstrb_q;
  logic [PprotW-1:0]   pprot_q;

  logic accept;
  logic timeout_hit;

  assign accept      = (state_q == StIdle) && req_valid;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    rsp_d     = rsp_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        psel    = 1'b1;
        state_d = StAccess;
      end
      StAccess: begin
        psel    = 1'b1;
        penable = 1'b1;
        // pready takes priority over an expiring timeout
        if (pready) begin
          rsp_d.rdata = '0;
          if (!pwrite_q) rsp_d.rdata[DATA_W-1:0] = prdata;
          rsp_d.err     = pslverr;
          rsp_d.timeout = 1'b0;
          state_d       = StResp;
        end else if (timeout_hit) begin
          rsp_d.rdata   = '0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= StIdle;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
    end else if (accept) begin
      paddr_q  <= req_addr;
      pwrite_q <= req_write;
      pwdata_q <= req_wdata;
      pstrb_q  <= req_write ? req_strb : '0;
      pprot_q  <= req_prot;
    end
  end

  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: doc/apb_requester.md
# apb_requester

Single-transaction APB4 requester. Accepts one read/write command on a valid/ready request channel, runs it through the APB SETUP/ACCESS phases, and returns read data and error status on a valid/ready response channel. Sits directly upstream of any APB completer in the library, converting core-side or bus-side traffic into APB transfers. It includes an optional access-phase timeout so a hung completer cannot stall the requester.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width (8, 16 or 32)
- TIMEOUT_CYCLES, 0, number of ACCESS-phase wait cycles before abort; 0 disables the timeout

Ports:
- pclk  in  1  clock; single clock domain
- preset  in  1  reset, synchronous, active-high
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  write byte strobes
- req_prot  in  3  protection attributes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- paddr, pwrite, pwdata, pstrb, pprot  out  ADDR_W/1/DATA_W/DATA_W/8/3  APB request fields
- psel, penable  out  1  APB phase controls
- pready, prdata, pslverr  in  1/DATA_W/1  APB completer response

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready, register all request fields and go to SETUP.
- SETUP: psel = 1, penable = 0. Go unconditionally to ACCESS.
- ACCESS: psel = 1, penable = 1. On pready, capture prdata (reads only) and pslverr, then go to RESP.
- ACCESS timeout: a wait counter counts ACCESS cycles with pready = 0. When the count equals TIMEOUT_CYCLES (nonzero), drop psel/penable and go to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- RESP: psel = 0, rsp_valid = 1, response fields stable. On rsp_ready, go to IDLE.
- pstrb = req_strb for writes and is forced to 0 for reads.
- paddr, pwrite, pwdata, pstrb and pprot are held constant from SETUP through the end of ACCESS.
- Only one outstanding transfer. req_ready is low in every state except IDLE.
- pready or pslverr arriving outside ACCESS is ignored.
- Timeout and pready in the same cycle: pready wins, and the response is a normal completion.

## Timing
- Reset (preset high at an edge): state = IDLE. On the next edge, req_ready = 1 and all of the following are 0: rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, paddr, pwrite, pwdata, pstrb, pprot.
- Reset mid-transfer aborts it with no response; psel drops at that same edge.
- Accept at edge N. SETUP during cycle N+1. ACCESS from N+2.
- Zero-wait completer (pready high in the first ACCESS cycle): rsp_valid is high at N+3. Minimum turnaround from accept to next accept is 4 cycles with rsp_ready held high.
- Each pready-low cycle adds 1 cycle of latency.
- Timeout: rsp_valid rises at N + 3 + TIMEOUT_CYCLES.
- The wait counter is ceil(log2(TIMEOUT_CYCLES+1)) bits wide, saturates, and clears on entering SETUP.

## Structure
- apb_if_pkg holds:
  - the state enum type (apb_req_state_e);
  - a packed response struct (apb_rsp_t: rdata, err, timeout);
  - the localparam for PPROT width (3).
- Single module, no sub-module. The timeout counter is small enough to stay inline.

## Test plan
- Write, zero-wait: addr 0x10, wdata 0xDEADBEEF, strb 0xF -> psel at N+1, penable at N+2; rsp_valid at N+3 with err=0, rdata=0.
- Read with 3 wait states, prdata 0x12345678 -> rsp_valid at N+6, rsp_rdata 0x12345678; paddr stable throughout; pstrb=0.
- Read, pslverr=1 with pready -> rsp_err=1, rsp_timeout=0.
- TIMEOUT_CYCLES=4, pready never asserted -> psel drops after 4 wait cycles; rsp_valid with err=1, timeout=1, rdata=0.
- rsp_ready held low 5 cycles, req_valid held high -> req_ready stays 0 and the response holds stable; next accept happens the cycle after the rsp handshake.
- preset asserted during ACCESS -> psel/penable 0 and req_ready 1 next cycle; no rsp_valid.
